// File: rtl/mesh_wormhole_pkg.sv
// Shared definitions for the mesh wormhole switch allocator: flit type
// encodings, the per-output lock state and small flit-type helpers.
package mesh_wormhole_pkg;

    localparam logic [1:0] FLIT_BODY     = 2'b00;
    localparam logic [1:0] FLIT_TAIL     = 2'b01;
    localparam logic [1:0] FLIT_HEAD     = 2'b10;
    localparam logic [1:0] FLIT_HEADTAIL = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_e;

    // A flit that opens a packet and may therefore contend for an output.
    function automatic logic is_head(input logic [1:0] id);
        return (id == FLIT_HEAD) || (id == FLIT_HEADTAIL);
    endfunction

    // A flit whose transfer releases the output lock.
    function automatic logic is_tail(input logic [1:0] id);
        return (id == FLIT_TAIL) || (id == FLIT_HEADTAIL);
    endfunction

endpackage

// File: rtl/mesh_wormhole_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr_i
// (wrapping modulo N) wins. Returns both a one-hot grant and its index.
module rr_arbiter #(
    parameter int N  = 5,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    // Scan from the farthest position back toward ptr_i so the nearest
    // requester is the last one written and therefore wins.
    always_comb begin
        int c;
        gnt_o = '0;
        idx_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            c = int'(ptr_i) + k;
            if (c >= N) c = c - N;
            if (req_i[c]) begin
                gnt_o    = '0;
                gnt_o[c] = 1'b1;
                idx_o    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/mesh_wormhole_allocator.sv
// Wormhole switch allocator for a 5-port mesh node. Each output arbitrates
// among head flits round-robin, then stays locked to the winning input until
// its tail flit transfers. Drives crossbar selects, output valids and input
// FIFO pops. Optional per-output packet counters: define ALLOC_PKT_CNT_EN.
module mesh_wormhole_allocator
    import mesh_wormhole_pkg::*;
#(
    parameter int IN_N      = 5,
    parameter int OUT_M     = 5,
    parameter int FLIT_ID_W = 2
`ifdef ALLOC_PKT_CNT_EN
    ,parameter int CNT_W    = 16
`endif
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [IN_N-1:0]        in_vld_i,
    input  logic [IN_N*FLIT_ID_W-1:0] in_flit_id_i,
    input  logic [IN_N*OUT_M-1:0]  req_i,
    input  logic [OUT_M-1:0]       out_rdy_i,
    output logic [OUT_M*IN_N-1:0]  xbar_sel_o,
    output logic [OUT_M-1:0]       out_vld_o,
    output logic [IN_N-1:0]        in_pop_o,
    output logic [OUT_M-1:0]       out_busy_o
`ifdef ALLOC_PKT_CNT_EN
    ,output logic [OUT_M*CNT_W-1:0] out_pkt_cnt_o
`endif
);

    localparam int IW = (IN_N > 1) ? $clog2(IN_N) : 1;

    // Pops requested by each output; merged into in_pop_o below.
    logic [OUT_M-1:0][IN_N-1:0] pop_mat;

    genvar gi, gk;
    generate
        for (gi = 0; gi < OUT_M; gi++) begin : g_out
            alloc_state_e          state_q;
            logic [IW-1:0]         owner_q;
            logic [IW-1:0]         rr_ptr_q;
            logic [IN_N-1:0]       cand;
            logic [IN_N-1:0]       win_gnt;
            logic [IW-1:0]         win_idx;
            logic [FLIT_ID_W-1:0]  own_id;
            logic                  locked;
            logic                  own_vld;
            logic                  xfer;

            for (gk = 0; gk < IN_N; gk++) begin : g_cand
                assign cand[gk] = in_vld_i[gk] & req_i[gk*OUT_M + gi]
                                & is_head(in_flit_id_i[gk*FLIT_ID_W +: FLIT_ID_W]);
            end

            rr_arbiter #(.N(IN_N), .IW(IW)) u_arb (
                .req_i (cand),
                .ptr_i (rr_ptr_q),
                .gnt_o (win_gnt),
                .idx_o (win_idx)
            );

            // Outputs are forced quiet while reset is asserted so a
            // mid-packet reset never pops a flit.
            assign locked  = rst_ni & (state_q == LOCKED);
            assign own_vld = locked & in_vld_i[owner_q];
            assign own_id  = in_flit_id_i[int'(owner_q)*FLIT_ID_W +: FLIT_ID_W];
            assign xfer    = own_vld & out_rdy_i[gi];

            assign out_busy_o[gi]               = locked;
            assign out_vld_o[gi]                = own_vld;
            assign xbar_sel_o[gi*IN_N +: IN_N]  = locked ? (IN_N'(1) << owner_q) : '0;
            assign pop_mat[gi]                  = xfer ? (IN_N'(1) << owner_q) : '0;

            // Lock FSM: grant on any head candidate, release after the tail transfers.
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    state_q  <= IDLE;
                    owner_q  <= '0;
                    rr_ptr_q <= '0;
                end else begin
                    case (state_q)
                        IDLE: begin
                            if (|win_gnt) begin
                                state_q  <= LOCKED;
                                owner_q  <= win_idx;
                                rr_ptr_q <= (win_idx == IW'(IN_N - 1)) ? '0 : win_idx + 1'b1;
                            end
                        end
                        LOCKED: begin
                            if (xfer && is_tail(own_id)) state_q <= IDLE;
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end

`ifdef ALLOC_PKT_CNT_EN
            logic [CNT_W-1:0] cnt_q;

            // Count completed packets on this output; wraps naturally.
            always_ff @(posedge clk_i) begin
                if (!rst_ni)                     cnt_q <= '0;
                else if (xfer && is_tail(own_id)) cnt_q <= cnt_q + 1'b1;
            end

            assign out_pkt_cnt_o[gi*CNT_W +: CNT_W] = cnt_q;
`endif
        end

`ifndef SYNTHESIS
        for (gk = 0; gk < IN_N; gk++) begin : g_chk
            // A head flit must route to at most one output.
            a_req_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
                (in_vld_i[gk] && is_head(in_flit_id_i[gk*FLIT_ID_W +: FLIT_ID_W]))
                    |-> $onehot0(req_i[gk*OUT_M +: OUT_M]));
        end
`endif
    endgenerate

    // An input owns at most one output, so OR-merging pops is safe.
    always_comb begin
        in_pop_o = '0;
        for (int j = 0; j < OUT_M; j++) in_pop_o = in_pop_o | pop_mat[j];
    end

endmodule

// File: tb/tb_mesh_wormhole_allocator.sv
// Scoreboard bench for mesh_wormhole_allocator. Each input holds a queue of
// packet flits; a packet-level reference model (owner per output, round-robin
// pointer) predicts every cycle's outputs, which a monitor compares on the
// falling edge.
module tb_mesh_wormhole_allocator;

    localparam int IN_N  = 5;
    localparam int OUT_M = 5;
    localparam int CNT_W = 16;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic [IN_N-1:0]       in_vld_i = '0;
    logic [IN_N*2-1:0]     in_flit_id_i = '0;
    logic [IN_N*OUT_M-1:0] req_i = '0;
    logic [OUT_M-1:0]      out_rdy_i = '0;
    logic [OUT_M*IN_N-1:0] xbar_sel_o;
    logic [OUT_M-1:0]      out_vld_o;
    logic [IN_N-1:0]       in_pop_o;
    logic [OUT_M-1:0]      out_busy_o;
`ifdef ALLOC_PKT_CNT_EN
    logic [OUT_M*CNT_W-1:0] out_pkt_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    mesh_wormhole_allocator dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .in_vld_i     (in_vld_i),
        .in_flit_id_i (in_flit_id_i),
        .req_i        (req_i),
        .out_rdy_i    (out_rdy_i),
        .xbar_sel_o   (xbar_sel_o),
        .out_vld_o    (out_vld_o),
        .in_pop_o     (in_pop_o),
        .out_busy_o   (out_busy_o)
`ifdef ALLOC_PKT_CNT_EN
        ,.out_pkt_cnt_o (out_pkt_cnt_o)
`endif
    );

    typedef struct packed {
        logic [OUT_M*IN_N-1:0] sel;
        logic [OUT_M-1:0]      vld;
        logic [IN_N-1:0]       pop;
        logic [OUT_M-1:0]      busy;
`ifdef ALLOC_PKT_CNT_EN
        logic [OUT_M*CNT_W-1:0] cnt;
`endif
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Flit queue per input: entry = dest*4 + flit id.
    int   fq[IN_N][$];
    // Reference model: owning input per output (-1 = free) and next priority.
    int   owner[OUT_M];
    int   ptr[OUT_M];
    logic [CNT_W-1:0] pkt_cnt[OUT_M];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    task automatic add_pkt(input int src, input int dst, input int len);
        if (len == 1) fq[src].push_back(dst*4 + 3);
        else begin
            fq[src].push_back(dst*4 + 2);
            for (int k = 0; k < len - 2; k++) fq[src].push_back(dst*4 + 0);
            fq[src].push_back(dst*4 + 1);
        end
    endtask

    // Drive one cycle of stimulus and push the model's expected outputs.
    task automatic step(input logic [IN_N-1:0] vmask, input logic [OUT_M-1:0] rmask, input bit rst);
        exp_t e;
        logic [IN_N-1:0] vis;
        int f, c, o;
        @(posedge clk_i);
        #1;
        cyc++;
        vis = '0;
        req_i = '0;
        in_flit_id_i = '0;
        for (int i = 0; i < IN_N; i++) begin
            if (fq[i].size() > 0) begin
                f = fq[i][0];
                vis[i] = vmask[i];
                in_flit_id_i[i*2 +: 2] = 2'(f % 4);
                req_i[i*OUT_M + f/4] = 1'b1;
            end
        end
        in_vld_i  = vis;
        out_rdy_i = rmask;
        rst_ni    = !rst;
        e = '0;
        if (rst) begin
            for (int j = 0; j < OUT_M; j++) begin
                owner[j] = -1; ptr[j] = 0; pkt_cnt[j] = '0;
            end
        end else begin
            for (int j = 0; j < OUT_M; j++) begin
                if (owner[j] >= 0) begin
                    o = owner[j];
                    e.busy[j] = 1'b1;
                    e.sel[j*IN_N + o] = 1'b1;
                    e.vld[j] = vis[o];
                    if (vis[o] && rmask[j]) begin
                        e.pop[o] = 1'b1;
                        if (fq[o][0] % 4 == 1 || fq[o][0] % 4 == 3) begin
                            owner[j] = -1;
                            pkt_cnt[j] = pkt_cnt[j] + 1'b1;
                            $display("[TB] cycle %0d: packet in%0d -> out%0d delivered", cyc, o, j);
                        end
                    end
                end else begin
                    for (int k = 0; k < IN_N; k++) begin
                        c = (ptr[j] + k) % IN_N;
                        if (owner[j] < 0 && vis[c] && fq[c][0] / 4 == j && fq[c][0] % 4 >= 2) begin
                            owner[j] = c;
                            ptr[j] = (c + 1) % IN_N;
                        end
                    end
                end
            end
            for (int i = 0; i < IN_N; i++) if (e.pop[i]) void'(fq[i].pop_front());
        end
`ifdef ALLOC_PKT_CNT_EN
        for (int j = 0; j < OUT_M; j++) e.cnt[j*CNT_W +: CNT_W] = pkt_cnt[j];
`endif
        sb.push_back(e);
    endtask

    task automatic flush();
        for (int i = 0; i < IN_N; i++) fq[i].delete();
    endtask

    task automatic run_idle(input int n);
        for (int k = 0; k < n; k++) step('1, '1, 1'b0);
    endtask

    // Monitor: compares the pending expectation against the DUT mid-cycle.
    always @(negedge clk_i) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("xbar_sel", 128'(xbar_sel_o), 128'(e.sel));
            chk("out_vld",  128'(out_vld_o),  128'(e.vld));
            chk("in_pop",   128'(in_pop_o),   128'(e.pop));
            chk("out_busy", 128'(out_busy_o), 128'(e.busy));
`ifdef ALLOC_PKT_CNT_EN
            chk("pkt_cnt",  128'(out_pkt_cnt_o), 128'(e.cnt));
`endif
        end
    end

    initial begin
        logic [IN_N-1:0]  vm;
        logic [OUT_M-1:0] rm;
        for (int j = 0; j < OUT_M; j++) begin owner[j] = -1; ptr[j] = 0; pkt_cnt[j] = '0; end
        step('1, '1, 1'b1);
        step('1, '1, 1'b1);

        // Single-flit packet.
        add_pkt(0, 2, 1);
        run_idle(4);

        // Contention on output 4, 4-flit packets.
        add_pkt(1, 4, 4);
        add_pkt(3, 4, 4);
        run_idle(13);

        // Backpressure after the second flit.
        add_pkt(1, 4, 4);
        for (int k = 0; k < 3; k++) step('1, '1, 1'b0);
        for (int k = 0; k < 3; k++) step('1, 5'b01111, 1'b0);
        run_idle(5);

        // Bubble on the owner while another input contends.
        add_pkt(2, 0, 4);
        add_pkt(4, 0, 1);
        step('1, '1, 1'b0);
        step('1, '1, 1'b0);
        step(5'b11011, '1, 1'b0);
        step(5'b11011, '1, 1'b0);
        run_idle(8);

        // Parallel grants on independent outputs.
        add_pkt(0, 1, 2);
        add_pkt(2, 3, 2);
        run_idle(5);

        // Reset in the middle of a packet.
        add_pkt(1, 4, 4);
        run_idle(3);
        step('1, '1, 1'b1);
        flush();
        run_idle(3);

        // Randomized traffic with bubbles, backpressure and rare resets.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < IN_N; i++)
                if (fq[i].size() < 3 && $urandom_range(3) == 0)
                    add_pkt(i, int'($urandom_range(OUT_M - 1)), int'($urandom_range(5, 1)));
            for (int i = 0; i < IN_N; i++) vm[i] = ($urandom_range(9) < 8);
            for (int j = 0; j < OUT_M; j++) rm[j] = ($urandom_range(9) < 7);
            if ($urandom_range(499) == 0) begin
                step(vm, rm, 1'b1);
                flush();
            end else begin
                step(vm, rm, 1'b0);
            end
        end

        @(negedge clk_i);
        @(negedge clk_i);
        chk("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mesh_wormhole_allocator.md
Name: mesh_wormhole_allocator

Overview:
- Switch allocator for the 5-port mesh wormhole node; sits between the input FIFOs/route units and the crossbar.
- Per output port: grants the port to one input on a head flit (round-robin among contenders) and holds the lock until the tail flit transfers.
- Drives crossbar select, output valid and input FIFO pops.

Parameters:
- IN_N, 5, number of input channels
- OUT_M, 5, number of output channels
- FLIT_ID_W, 2, flit type field width
- CNT_W, 16, packet counter width (optional feature only)

Ports:
- clk_i  input  1  clock, all logic on rising edge
- rst_ni  input  1  reset, synchronous, active-low
- in_vld_i  input  IN_N  input FIFO i non-empty (front flit valid)
- in_flit_id_i  input  IN_N*FLIT_ID_W  front-flit type of input i, slice [i*FLIT_ID_W +: FLIT_ID_W]
- req_i  input  IN_N*OUT_M  route result of input i, one-hot, bit i*OUT_M+j = wants output j
- out_rdy_i  input  OUT_M  downstream ready per output
- xbar_sel_o  output  OUT_M*IN_N  one-hot input select per output, slice [j*IN_N +: IN_N]
- out_vld_o  output  OUT_M  output j carries a valid flit
- in_pop_o  output  IN_N  pop front flit of input i
- out_busy_o  output  OUT_M  output j locked to a packet
- out_pkt_cnt_o  output  OUT_M*CNT_W  present only with ALLOC_PKT_CNT_EN

Behaviour:
- Flit ids (package): BODY=2'b00, TAIL=2'b01, HEAD=2'b10, HEADTAIL=2'b11 (single-flit packet).
- Per-output FSM states: IDLE, LOCKED; owner_q (index, $clog2(IN_N) bits); rr_ptr_q.
- Reset (rst_ni=0 at edge): all FSMs to IDLE, owner_q=0, rr_ptr_q=0, counters=0. Outputs during/after reset: xbar_sel_o=0, out_vld_o=0, in_pop_o=0, out_busy_o=0. Mid-packet reset drops the lock; no pops in the reset cycle.
- IDLE, output j:
  - Candidate i iff in_vld_i[i] & req_i[i*OUT_M+j] & id in {HEAD, HEADTAIL}.
  - Round-robin pick starting at rr_ptr_q; on any candidate: LOCKED next cycle, owner_q=winner, rr_ptr_q=(winner+1) mod IN_N.
  - No data moves in the arbitration cycle; xbar_sel_o[j]=0, out_vld_o[j]=0.
  - Head latency: request cycle N, head transfers earliest cycle N+1.
- LOCKED, output j:
  - xbar_sel_o[j]=onehot(owner_q); out_busy_o[j]=1; out_vld_o[j]=in_vld_i[owner_q].
  - xfer = out_vld_o[j] & out_rdy_i[j]; in_pop_o[owner_q]=xfer.
  - xfer with id TAIL or HEADTAIL: IDLE next cycle. Other xfers, or no xfer: stay LOCKED.
  - req_i is ignored while LOCKED; a bubble (in_vld low) or backpressure holds the lock indefinitely.
- in_pop_o[i] = OR over outputs; at most one bit set, since an input owns at most one output (its front flit is its own packet until the tail pops).
- req_i zero or non-one-hot with a head: the input is not a candidate for any output whose bit is clear; multiple set bits are a protocol violation (simulation assertion).
- Released output: next allocation occurs in the IDLE cycle after the tail; back-to-back packets therefore have 1 idle cycle per port.
- Outputs are independent; several outputs may grant in the same cycle.

Optional Feature:
- Macro ALLOC_PKT_CNT_EN.
- Defined: out_pkt_cnt_o exists; counter j increments on each TAIL/HEADTAIL xfer on output j, wraps at 2^CNT_W, cleared by reset.
- Undefined: port and counters absent; all other behaviour identical.

Decomposition:
- Package mesh_wormhole_pkg: flit id localparams (BODY/TAIL/HEAD/HEADTAIL), FSM state enum (IDLE/LOCKED).
- Sub-module rr_arbiter: parameter N; inputs req, ptr; output one-hot gnt and index; purely combinational, instantiated OUT_M times.
- Allocator top: FSMs, owner/ptr registers, muxing.

Test Plan:
- Single flit, IN_N=OUT_M=5, all out_rdy_i=1: input0 HEADTAIL req output2 at cycle 0 -> cycle 1 out_busy_o[2]=1, xbar_sel_o[2]=5'b00001, out_vld_o[2]=1, in_pop_o[0]=1; cycle 2 out_busy_o[2]=0.
- Contention, rr_ptr=0: inputs 1 and 3 HEAD to output 4 in the same cycle, 4-flit packets -> input1 gets flits on cycles 1-4; IDLE cycle 5; input3 granted, flits cycles 6-9; rr_ptr ends at 4.
- Backpressure: out_rdy_i[4]=0 for 3 cycles after the 2nd flit -> out_vld_o[4]=1 held, in_pop_o=0, lock kept, remaining flits follow on ready.
- Bubble: owner in_vld_i low 2 cycles mid-packet while another input requests the same output -> out_vld_o=0, no grant change, packet completes intact.
- Parallel: input0->output1 and input2->output3 in the same cycle -> both granted cycle 1, in_pop_o=5'b00101.
- Reset: rst_ni=0 for 1 cycle after the 2nd of 4 flits -> next cycle all outputs 0, FSMs IDLE; with ALLOC_PKT_CNT_EN, counters=0.
